input_buffer_unit: RTL and testbench

- Per-input-port stage directly upstream of the switch allocator; one instance per router port (PORT_NUM instances).
- Buffers incoming flits in a FIFO and performs XY route computation on head flits.
- Tracks wormhole packet state and presents switch_request/out_port to the allocator.
- Pops the FIFO head onto the crossbar input on grant (valid_sel); generates on/off backpressure toward the upstream router.

---
 rtl/noc_params.sv | 49 ++++
 rtl/input_buffer_unit_if.sv | 23 ++
 rtl/circular_buffer.sv | 64 ++++++
 rtl/input_buffer_unit.sv | 92 +++++++++
 tb/tb_input_buffer_unit.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/noc_params.sv
// Shared NoC types: port and flit encodings, flit layout, and the XY routing function.
package noc_params;

  localparam int unsigned PORT_NUM         = 5;
  localparam int unsigned PORT_SIZE        = $clog2(PORT_NUM);
  localparam int unsigned DEST_ADDR_SIZE_X = 2;
  localparam int unsigned DEST_ADDR_SIZE_Y = 2;
  localparam int unsigned FLIT_DATA_SIZE   = 16;
  localparam int unsigned HEAD_DATA_SIZE   = FLIT_DATA_SIZE - DEST_ADDR_SIZE_X - DEST_ADDR_SIZE_Y;

  typedef enum logic [PORT_SIZE-1:0] {LOCAL, NORTH, SOUTH, WEST, EAST} port_t;

  typedef enum logic [1:0] {HEAD, BODY, TAIL, HEADTAIL} flit_label_t;

  typedef struct packed {
    logic [DEST_ADDR_SIZE_X-1:0] dest_x;
    logic [DEST_ADDR_SIZE_Y-1:0] dest_y;
    logic [HEAD_DATA_SIZE-1:0]   data;
  } head_payload_t;

  typedef struct packed {
    logic [FLIT_DATA_SIZE-1:0] data;
  } body_payload_t;

  typedef union packed {
    head_payload_t head;
    body_payload_t body;
  } flit_payload_t;

  typedef struct packed {
    flit_label_t   label;
    flit_payload_t payload;
  } flit_t;

  // Dimension-ordered routing: resolve X completely before Y.
  function automatic port_t xy_route(
    input logic [DEST_ADDR_SIZE_X-1:0] dest_x,
    input logic [DEST_ADDR_SIZE_Y-1:0] dest_y,
    input logic [DEST_ADDR_SIZE_X-1:0] cur_x,
    input logic [DEST_ADDR_SIZE_Y-1:0] cur_y
  );
    if (dest_x > cur_x)      return EAST;
    else if (dest_x < cur_x) return WEST;
    else if (dest_y > cur_y) return SOUTH;
    else if (dest_y < cur_y) return NORTH;
    else                     return LOCAL;
  endfunction

endpackage

// File: rtl/input_buffer_unit_if.sv
// Flit/allocator handshake bundle between an input port's environment and its buffer unit.
interface input_buffer_unit_if;
  import noc_params::*;

  flit_t data_i;
  logic  valid_flit_i;
  logic  on_off_o;
  logic  switch_request_o;
  port_t out_port_o;
  logic  valid_sel_i;
  flit_t flit_o;
  logic  error_o;

  modport master (
    output data_i, valid_flit_i, valid_sel_i,
    input  on_off_o, switch_request_o, out_port_o, flit_o, error_o
  );

  modport slave (
    input  data_i, valid_flit_i, valid_sel_i,
    output on_off_o, switch_request_o, out_port_o, flit_o, error_o
  );
endinterface

// File: rtl/circular_buffer.sv
// Flit FIFO with wrap-around pointers, occupancy count and on/off hysteresis toward upstream.
module circular_buffer
  import noc_params::*;
#(
  parameter int unsigned BUFFER_SIZE   = 8,
  parameter int unsigned OFF_THRESHOLD = 6,
  parameter int unsigned ON_THRESHOLD  = 3
) (
  input  logic  clk,
  input  logic  rst,
  input  flit_t data_i,
  input  logic  read_i,
  input  logic  write_i,
  output flit_t data_o,
  output logic  is_empty_o,
  output logic  is_full_o,
  output logic  on_off_o
);

  localparam int unsigned PTR_W = $clog2(BUFFER_SIZE);
  localparam int unsigned OCC_W = PTR_W + 1;

  flit_t            mem [BUFFER_SIZE];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [OCC_W-1:0] occupancy;
  logic [OCC_W-1:0] occ_next;
  logic             do_read;
  logic             do_write;

  assign is_empty_o = (occupancy == '0);
  assign is_full_o  = (occupancy == OCC_W'(BUFFER_SIZE));
  assign do_read    = read_i && !is_empty_o;
  // A full buffer still accepts a write when the head leaves in the same cycle.
  assign do_write   = write_i && (!is_full_o || do_read);
  assign data_o     = is_empty_o ? '0 : mem[rd_ptr];

  always_comb begin
    occ_next = occupancy;
    if (do_write && !do_read)      occ_next = occupancy + OCC_W'(1);
    else if (do_read && !do_write) occ_next = occupancy - OCC_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      occupancy <= '0;
      on_off_o  <= 1'b1;
    end else begin
      if (do_write) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_read)  rd_ptr <= rd_ptr + PTR_W'(1);
      occupancy <= occ_next;
      if (occ_next >= OCC_W'(OFF_THRESHOLD))     on_off_o <= 1'b0;
      else if (occ_next <= OCC_W'(ON_THRESHOLD)) on_off_o <= 1'b1;
    end
  end

  // Storage needs no reset: empty entries are never presented at data_o.
  always_ff @(posedge clk) begin
    if (do_write) mem[wr_ptr] <= data_i;
  end

endmodule

// File: rtl/input_buffer_unit.sv
// Router input port: buffers flits, routes head flits XY, tracks wormhole state, requests the allocator.
module input_buffer_unit
  import noc_params::*;
#(
  parameter int unsigned                 BUFFER_SIZE   = 8,
  parameter int unsigned                 OFF_THRESHOLD = 6,
  parameter int unsigned                 ON_THRESHOLD  = 3,
  parameter logic [DEST_ADDR_SIZE_X-1:0] X_CURRENT     = '0,
  parameter logic [DEST_ADDR_SIZE_Y-1:0] Y_CURRENT     = '0
) (
  input logic                clk,
  input logic                rst,
  input_buffer_unit_if.slave bus
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t state;
  state_t state_next;
  port_t  out_port;
  port_t  out_port_next;
  logic   error;
  logic   error_next;
  logic   read;
  logic   is_empty;
  logic   is_full;
  flit_t  head;

  circular_buffer #(
    .BUFFER_SIZE   (BUFFER_SIZE),
    .OFF_THRESHOLD (OFF_THRESHOLD),
    .ON_THRESHOLD  (ON_THRESHOLD)
  ) u_buf (
    .clk        (clk),
    .rst        (rst),
    .data_i     (bus.data_i),
    .read_i     (read),
    .write_i    (bus.valid_flit_i),
    .data_o     (head),
    .is_empty_o (is_empty),
    .is_full_o  (is_full),
    .on_off_o   (bus.on_off_o)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      out_port <= LOCAL;
      error    <= 1'b0;
    end else begin
      state    <= state_next;
      out_port <= out_port_next;
      error    <= error_next;
    end
  end

  always_comb begin
    state_next    = state;
    out_port_next = out_port;
    error_next    = error;
    read          = 1'b0;
    case (state)
      IDLE: begin
        if (!is_empty) begin
          if (head.label == HEAD || head.label == HEADTAIL) begin
            out_port_next = xy_route(head.payload.head.dest_x, head.payload.head.dest_y,
                                     X_CURRENT, Y_CURRENT);
            state_next    = ACTIVE;
          end else begin
            // Orphan body/tail without a head: drop it so the port cannot lock up.
            read       = 1'b1;
            error_next = 1'b1;
          end
        end
      end
      ACTIVE: begin
        if (bus.valid_sel_i && !is_empty) begin
          read = 1'b1;
          if (head.label == TAIL || head.label == HEADTAIL) state_next = IDLE;
        end
      end
    endcase
    if (bus.valid_sel_i && !(state == ACTIVE && !is_empty)) error_next = 1'b1;
    if (bus.valid_flit_i && is_full && !read)               error_next = 1'b1;
  end

  assign bus.switch_request_o = (state == ACTIVE) && !is_empty;
  assign bus.out_port_o       = out_port;
  assign bus.error_o          = error;
  assign bus.flit_o           = head;

endmodule

// File: tb/tb_input_buffer_unit.sv
// Directed bench for input_buffer_unit at router (1,1), BUFFER_SIZE=8, OFF=6, ON=3.
module tb_input_buffer_unit;
  import noc_params::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  input_buffer_unit_if bus ();

  input_buffer_unit #(
    .BUFFER_SIZE   (8),
    .OFF_THRESHOLD (6),
    .ON_THRESHOLD  (3),
    .X_CURRENT     (2'd1),
    .Y_CURRENT     (2'd1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  port_t       exp_port [4] = '{EAST, WEST, SOUTH, LOCAL};
  int unsigned rt_x     [4] = '{3, 0, 1, 1};
  int unsigned rt_y     [4] = '{0, 1, 2, 1};
  flit_t       pkt [4];
  flit_t       bp  [9];
  flit_t       wr  [20];
  flit_t       f;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic flit_t mk_head(flit_label_t lb, int unsigned dx, int unsigned dy, int unsigned d);
    flit_t r;
    r.label               = lb;
    r.payload.head.dest_x = DEST_ADDR_SIZE_X'(dx);
    r.payload.head.dest_y = DEST_ADDR_SIZE_Y'(dy);
    r.payload.head.data   = HEAD_DATA_SIZE'(d);
    return r;
  endfunction

  function automatic flit_t mk_body(flit_label_t lb, int unsigned d);
    flit_t r;
    r.label             = lb;
    r.payload.body.data = FLIT_DATA_SIZE'(d);
    return r;
  endfunction

  task automatic do_reset();
    bus.valid_flit_i = 1'b0;
    bus.valid_sel_i  = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    checks = 0;
    errors = 0;
    bus.data_i       = '0;
    bus.valid_flit_i = 1'b0;
    bus.valid_sel_i  = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();

    check("rst_req",    32'(bus.switch_request_o), 0);
    check("rst_on_off", 32'(bus.on_off_o), 1);
    check("rst_err",    32'(bus.error_o), 0);
    check("rst_port",   32'(bus.out_port_o), 32'(LOCAL));
    check("rst_flit",   32'(bus.flit_o), 0);

    // Mid-stream reset: stray grant sets error, then 3 flits of a packet to (3,0) buffered.
    bus.valid_sel_i = 1'b1;
    tick();
    bus.valid_sel_i  = 1'b0;
    bus.valid_flit_i = 1'b1;
    bus.data_i = mk_head(HEAD, 3, 0, 12'h111);
    tick();
    bus.data_i = mk_body(BODY, 16'h2222);
    tick();
    bus.data_i = mk_body(BODY, 16'h3333);
    tick();
    bus.valid_flit_i = 1'b0;
    check("pre_rst_req",  32'(bus.switch_request_o), 1);
    check("pre_rst_err",  32'(bus.error_o), 1);
    check("pre_rst_port", 32'(bus.out_port_o), 32'(EAST));
    rst = 1'b1;
    #1;
    check("mid_rst_req",    32'(bus.switch_request_o), 0);
    check("mid_rst_on_off", 32'(bus.on_off_o), 1);
    check("mid_rst_err",    32'(bus.error_o), 0);
    check("mid_rst_port",   32'(bus.out_port_o), 32'(LOCAL));
    check("mid_rst_empty",  32'(bus.flit_o), 0);
    tick();
    rst = 1'b0;
    tick();

    // Single-flit packets covering every XY direction.
    for (int i = 0; i < 4; i++) begin
      f = mk_head(HEADTAIL, rt_x[i], rt_y[i], 12'h400 + 12'(i));
      bus.valid_flit_i = 1'b1;
      bus.data_i = f;
      tick();
      bus.valid_flit_i = 1'b0;
      check("ht_req_t1", 32'(bus.switch_request_o), 0);
      tick();
      check("ht_port", 32'(bus.out_port_o), 32'(exp_port[i]));
      check("ht_req",  32'(bus.switch_request_o), 1);
      check("ht_flit", 32'(bus.flit_o), 32'(f));
      bus.valid_sel_i = 1'b1;
      tick();
      bus.valid_sel_i = 1'b0;
      check("ht_idle", 32'(bus.switch_request_o), 0);
      tick();
    end
    check("ht_err", 32'(bus.error_o), 0);

    // Four-flit packet to (1,0) with a grant every cycle from t=2.
    pkt[0] = mk_head(HEAD, 1, 0, 12'hA01);
    pkt[1] = mk_body(BODY, 16'hB002);
    pkt[2] = mk_body(BODY, 16'hB003);
    pkt[3] = mk_body(TAIL, 16'hC004);
    for (int c = 0; c < 7; c++) begin
      if (c == 2) check("p4_port", 32'(bus.out_port_o), 32'(NORTH));
      if (c >= 2 && c <= 5) begin
        check("p4_req",  32'(bus.switch_request_o), 1);
        check("p4_flit", 32'(bus.flit_o), 32'(pkt[c-2]));
      end
      if (c == 6) check("p4_idle", 32'(bus.switch_request_o), 0);
      bus.valid_flit_i = (c < 4);
      if (c < 4) bus.data_i = pkt[c];
      bus.valid_sel_i = (c >= 2 && c <= 5);
      tick();
    end
    check("p4_err", 32'(bus.error_o), 0);

    // Backpressure: fill to 8, overflow on the 9th, then drain 5 to occupancy 3.
    bp[0] = mk_head(HEAD, 1, 1, 12'h0D0);
    for (int j = 1; j < 9; j++) bp[j] = mk_body(BODY, 16'hD000 + 16'(j));
    for (int c = 0; c < 15; c++) begin
      if (c == 5)  check("bp_on_occ5",   32'(bus.on_off_o), 1);
      if (c == 6)  check("bp_off_occ6",  32'(bus.on_off_o), 0);
      if (c == 7)  check("bp_off_occ7",  32'(bus.on_off_o), 0);
      if (c == 8)  check("bp_err_full",  32'(bus.error_o), 0);
      if (c == 9)  check("bp_err_ovf",   32'(bus.error_o), 1);
      if (c >= 9 && c <= 13) check("bp_drain_flit", 32'(bus.flit_o), 32'(bp[c-9]));
      if (c == 13) check("bp_off_occ4",  32'(bus.on_off_o), 0);
      if (c == 14) check("bp_on_occ3",   32'(bus.on_off_o), 1);
      bus.valid_flit_i = (c <= 8);
      if (c <= 8) bus.data_i = bp[c];
      bus.valid_sel_i = (c >= 9 && c <= 13);
      tick();
    end
    do_reset();

    // Orphan BODY flit in IDLE is discarded one cycle after it lands.
    f = mk_body(BODY, 16'hEEEE);
    bus.valid_flit_i = 1'b1;
    bus.data_i = f;
    tick();
    bus.valid_flit_i = 1'b0;
    check("orphan_flit", 32'(bus.flit_o), 32'(f));
    check("orphan_req",  32'(bus.switch_request_o), 0);
    check("orphan_err0", 32'(bus.error_o), 0);
    tick();
    check("orphan_err1",  32'(bus.error_o), 1);
    check("orphan_req2",  32'(bus.switch_request_o), 0);
    check("orphan_empty", 32'(bus.flit_o), 0);
    do_reset();

    // 20-flit packet: fill to full, then push+pop together, then drain; order across wrap.
    wr[0] = mk_head(HEAD, 1, 1, 12'h5A0);
    for (int j = 1; j < 19; j++) wr[j] = mk_body(BODY, 16'hA000 + 16'(j));
    wr[19] = mk_body(TAIL, 16'hA019);
    for (int c = 0; c < 29; c++) begin
      if (c == 8)  check("wrap_req_full", 32'(bus.switch_request_o), 1);
      if (c >= 8 && c <= 27) check("wrap_flit", 32'(bus.flit_o), 32'(wr[c-8]));
      if (c == 9)  check("wrap_err_c9",  32'(bus.error_o), 0);
      if (c == 20) check("wrap_err_c20", 32'(bus.error_o), 0);
      if (c == 28) begin
        check("wrap_idle",  32'(bus.switch_request_o), 0);
        check("wrap_empty", 32'(bus.flit_o), 0);
        check("wrap_err",   32'(bus.error_o), 0);
      end
      bus.valid_flit_i = (c < 20);
      if (c < 20) bus.data_i = wr[c];
      bus.valid_sel_i = (c >= 8 && c <= 27);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
